// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// The master drives the payload word; the slave is the serializer.
interface seq_pattern_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              dout;
    logic              dout_valid;
    logic              frame_done;
    logic              busy;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid, frame_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid, frame_done, busy
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern, then payload (both MSB first), then an idle gap.
// All serial outputs are registered from the next-state values, so they depend on state only.
module seq_pattern_tx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1001,
    parameter int                GAP_CYC  = 1
) (
    input logic             clk,
    input logic             rst,
    seq_pattern_tx_if.slave bus
);
    localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_B = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
    localparam int CW    = $clog2(MAX_B + 1);

    localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] DATA_LD = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    // Sparse encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_SYNC = 3'b001,
        S_DATA = 3'b010,
        S_GAP  = 3'b100
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic              r_dout;
    logic              r_dout_valid;
    logic              r_frame_done;
    logic              w_dout_nxt;
    logic              w_dout_valid_nxt;
    logic              w_frame_done_nxt;

    function automatic logic sync_bit(input logic [CW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (idx == CW'(i)) b = SYNC_PAT[i];
        end
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shreg      <= w_shreg_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        case (r_state)
            S_IDLE: begin
                if (bus.din_valid) begin
                    w_state_nxt = S_SYNC;
                    w_cnt_nxt   = SYNC_LD;
                    w_shreg_nxt = bus.din;
                end
            end
            S_SYNC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = DATA_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    w_state_nxt = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    // The bit on the wire is always the MSB, so advance by shifting left.
                    w_cnt_nxt   = r_cnt - CW'(1);
                    w_shreg_nxt = r_shreg << 1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_shreg_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_dout_nxt       = 1'b0;
        w_dout_valid_nxt = 1'b0;
        w_frame_done_nxt = 1'b0;
        case (w_state_nxt)
            S_SYNC: begin
                w_dout_valid_nxt = 1'b1;
                w_dout_nxt       = sync_bit(w_cnt_nxt);
            end
            S_DATA: begin
                w_dout_valid_nxt = 1'b1;
                w_dout_nxt       = w_shreg_nxt[DATA_W-1];
                w_frame_done_nxt = (w_cnt_nxt == '0);
            end
            default: ;
        endcase
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.din_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_GAP);
endmodule
